// File: rtl/stream_deserializer_1_4.sv
// 1:4 stream deserializer: gathers WIDTH-bit words into four lanes.
// A group closes on its fourth word or on in_last; out_mask marks filled lanes.
module stream_deserializer_1_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] d3,
    output logic [3:0]       out_mask
);

    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] lane_q [4];
    logic [WIDTH-1:0] lane_d [4];
    logic [3:0]       mask_q, mask_d;
    logic             valid_q, valid_d;
    logic             in_hs, out_hs;

    always_comb begin
        in_ready = !rst && (!valid_q || out_ready);
        in_hs    = in_valid && in_ready;
        out_hs   = valid_q && out_ready;
        cnt_d    = cnt_q;
        lane_d   = lane_q;
        mask_d   = mask_q;
        valid_d  = valid_q;
        if (out_hs) begin
            valid_d = 1'b0;
        end
        if (in_hs) begin
            // First word of a group wipes whatever the previous group left.
            if (cnt_q == 2'd0) begin
                for (int i = 0; i < 4; i++) begin
                    lane_d[i] = '0;
                end
                mask_d = 4'b0000;
            end
            lane_d[cnt_q] = in_data;
            mask_d[cnt_q] = 1'b1;
            if (cnt_q == 2'd3 || in_last) begin
                valid_d = 1'b1;
                cnt_d   = 2'd0;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            mask_q  <= 4'b0000;
            valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            lane_q  <= lane_d;
        end
    end

    assign out_valid = valid_q;
    assign out_mask  = mask_q;
    assign d0        = lane_q[0];
    assign d1        = lane_q[1];
    assign d2        = lane_q[2];
    assign d3        = lane_q[3];

endmodule

// File: tb/tb_stream_deserializer_1_4.sv
// Bench for stream_deserializer_1_4: group-level model checked every cycle
// plus directed vectors with literal expectations.
module tb_stream_deserializer_1_4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d0, d1, d2, d3;
    logic [3:0]   out_mask;

    int total = 0;
    int bad   = 0;

    stream_deserializer_1_4 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .out_mask (out_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: words of the open group sit in a queue; a closed group is
    // presented zero-padded with a mask of its length.
    logic [W-1:0] grp [$];
    logic [W-1:0] m_lane [4];
    logic [3:0]   m_mask;
    logic         m_valid;

    always @(posedge clk) begin
        bit ihs, ohs;
        if (rst) begin
            grp.delete();
            m_valid = 1'b0;
            m_mask  = 4'b0;
            for (int i = 0; i < 4; i++) m_lane[i] = '0;
        end else begin
            ihs = in_valid && (!m_valid || out_ready);
            ohs = m_valid && out_ready;
            if (ohs) m_valid = 1'b0;
            if (ihs) begin
                grp.push_back(in_data);
                if (grp.size() == 4 || in_last) begin
                    m_valid = 1'b1;
                    m_mask  = 4'((1 << grp.size()) - 1);
                    for (int i = 0; i < 4; i++)
                        m_lane[i] = (i < grp.size()) ? grp[i] : '0;
                    grp.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst !== 1'bx) begin
            chk("in_ready", in_ready, !rst && (!m_valid || out_ready));
            chk("out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("d0", d0, m_lane[0]);
                chk("d1", d1, m_lane[1]);
                chk("d2", d2, m_lane[2]);
                chk("d3", d3, m_lane[3]);
                chk("mask", out_mask, m_mask);
            end
        end
    end

    // Inputs change 1 time unit after a rising edge; returns at edge+1.
    task automatic step(input logic iv, input logic [W-1:0] dat,
                        input logic lst, input logic ordy);
        in_valid  = iv;
        in_data   = dat;
        in_last   = lst;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic lanes(input string nm, input logic v,
                         input logic [4*W-1:0] l, input logic [3:0] m);
        chk({nm, ".valid"}, out_valid, v);
        chk({nm, ".lanes"}, {d3, d2, d1, d0}, l);
        chk({nm, ".mask"}, out_mask, m);
    endtask

    int groups;

    initial begin
        rst = 1'b1;
        in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
        @(posedge clk); #1;
        step(1, 4'h5, 0, 1);
        step(1, 4'h6, 0, 1);
        lanes("reset", 0, 16'h0000, 4'b0000);
        chk("reset.in_ready", in_ready, 0);
        rst = 1'b0;

        // full group
        step(1, 4'hA, 0, 1);
        step(1, 4'hB, 0, 1);
        step(1, 4'hC, 0, 1);
        step(1, 4'hD, 0, 1);
        lanes("full", 1, 16'hDCBA, 4'b1111);
        step(0, 4'h0, 0, 1);
        chk("full.drop", out_valid, 0);

        // early close, then single-word group consumed in the same cycle
        step(1, 4'h7, 0, 1);
        step(1, 4'hA, 1, 1);
        lanes("early", 1, 16'h00A7, 4'b0011);
        step(1, 4'h3, 1, 1);
        lanes("single", 1, 16'h0003, 4'b0001);
        step(0, 4'h0, 0, 1);
        chk("single.drop", out_valid, 0);

        // backpressure
        step(1, 4'h1, 0, 0);
        step(1, 4'h2, 0, 0);
        step(1, 4'h3, 0, 0);
        step(1, 4'h4, 0, 0);
        lanes("bp.done", 1, 16'h4321, 4'b1111);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1; in_data = 4'h5; in_last = 0; out_ready = 0;
            #1;
            chk("bp.in_ready", in_ready, 0);
            @(posedge clk); #1;
            lanes("bp.hold", 1, 16'h4321, 4'b1111);
        end
        in_valid = 1; in_data = 4'h5; in_last = 0; out_ready = 1;
        #1;
        chk("bp.release", in_ready, 1);
        @(posedge clk); #1;
        lanes("bp.next", 0, 16'h0005, 4'b0001);
        step(1, 4'h6, 1, 1);
        lanes("bp.pair", 1, 16'h0065, 4'b0011);
        step(0, 4'h0, 0, 1);

        // back-to-back stream of 12 words
        groups = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1; in_data = W'(i + 1); in_last = 0; out_ready = 1;
            #1;
            chk("b2b.in_ready", in_ready, 1);
            @(posedge clk); #1;
            if (out_valid) groups++;
            if (i % 4 == 3)
                lanes("b2b.grp", 1,
                      {W'(i + 1), W'(i), W'(i - 1), W'(i - 2)}, 4'b1111);
        end
        chk("b2b.groups", groups, 3);

        // pending group consumed while a last-word arrives
        step(1, 4'h9, 1, 1);
        lanes("sim", 1, 16'h0009, 4'b0001);
        step(0, 4'h0, 0, 1);

        // reset mid-group
        step(1, 4'h8, 0, 1);
        step(1, 4'h7, 0, 1);
        rst = 1'b1;
        in_valid = 1; in_data = 4'h6;
        #1;
        chk("rst.in_ready", in_ready, 0);
        @(posedge clk); #1;
        lanes("rst.mid", 0, 16'h0000, 4'b0000);
        rst = 1'b0;
        step(1, 4'hE, 0, 1);
        step(1, 4'hF, 0, 1);
        step(1, 4'h1, 0, 1);
        step(1, 4'h2, 0, 1);
        lanes("rst.clean", 1, 16'h21FE, 4'b1111);
        step(0, 4'h0, 0, 1);
        step(0, 4'h0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
